scan_mux: RTL and testbench

Parametrised N-channel, W-bit registered selector with manual and auto-scan modes. Drives board-level outputs (LEDR/HEX) from SW-sourced or internal data buses. In manual mode it works as a clocked N:1 mux with out-of-range clamping. In scan mode it steps through all channels, showing each for a programmable dwell period with a hold control.

---
 rtl/scan_mux.sv | 111 +++++++++++
 tb/tb_scan_mux.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : scan_mux
// Description : N-channel registered selector with manual select (clamped)
//               and auto-scan mode with programmable dwell and hold.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_mux #(
    parameter int CHANNELS = 7,
    parameter int WIDTH    = 1,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      out_valid,
    output logic                      wrap
);

    localparam int               c_dw_w       = $clog2(DWELL + 1);
    localparam logic [SEL_W-1:0] c_last_sel   = SEL_W'(CHANNELS - 1);
    localparam logic [c_dw_w-1:0] c_last_dwell = c_dw_w'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MANUAL = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_dw_w-1:0]   r_dwell_cnt;

    logic [WIDTH-1:0]    w_chan [CHANNELS];
    logic [SEL_W-1:0]    w_sel_clamp;
    logic [SEL_W-1:0]    w_scan_next;
    logic                w_advance;
    logic [SEL_W-1:0]    w_nxt_sel;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign w_chan[k] = data_in[k*WIDTH +: WIDTH];
    end

    assign w_sel_clamp = (sel > c_last_sel) ? c_last_sel : sel;
    assign w_scan_next = (cur_sel == c_last_sel) ? '0 : cur_sel + SEL_W'(1);
    assign w_advance   = (r_state == S_SCAN) && mode && !hold
                         && (r_dwell_cnt == c_last_dwell);

    // The index cur_sel takes on this edge; data_out is loaded from the same
    // index so the two outputs can never disagree.
    always_comb begin
        w_nxt_sel = cur_sel;
        case (r_state)
            S_IDLE:   w_nxt_sel = mode ? '0 : w_sel_clamp;
            S_MANUAL: w_nxt_sel = mode ? cur_sel : w_sel_clamp;
            S_SCAN: begin
                if (!mode) begin
                    w_nxt_sel = w_sel_clamp;
                end else if (w_advance) begin
                    w_nxt_sel = w_scan_next;
                end
            end
            default:  w_nxt_sel = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_dwell_cnt <= '0;
            data_out    <= '0;
            cur_sel     <= '0;
            out_valid   <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            cur_sel   <= w_nxt_sel;
            data_out  <= w_chan[w_nxt_sel];
            out_valid <= 1'b1;
            wrap      <= w_advance && (cur_sel == c_last_sel);
            case (r_state)
                S_IDLE: begin
                    r_state     <= mode ? S_SCAN : S_MANUAL;
                    r_dwell_cnt <= '0;
                end
                S_MANUAL: begin
                    r_state     <= mode ? S_SCAN : S_MANUAL;
                    r_dwell_cnt <= '0;
                end
                S_SCAN: begin
                    if (!mode) begin
                        r_state     <= S_MANUAL;
                        r_dwell_cnt <= '0;
                    end else if (!hold) begin
                        r_dwell_cnt <= w_advance ? '0 : r_dwell_cnt + c_dw_w'(1);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_dwell_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_mux
// Description : Scoreboard bench for scan_mux (7 channels x 4 bits, dwell 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_mux;

    localparam int CH = 7;
    localparam int W  = 4;
    localparam int SW = 3;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic [CH*W-1:0] data_in;
    logic [SW-1:0]   sel;
    logic            mode;
    logic            hold;
    logic [W-1:0]    data_out;
    logic [SW-1:0]   cur_sel;
    logic            out_valid;
    logic            wrap;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [3:0] d;
        logic [2:0] s;
        logic       v;
        logic       w;
    } exp_t;

    exp_t  sb[$];
    string names[$];

    scan_mux #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .SEL_W    (SW),
        .DWELL    (DW)
    ) dut (
        .clock     (clk),
        .resetn    (resetn),
        .data_in   (data_in),
        .sel       (sel),
        .mode      (mode),
        .hold      (hold),
        .data_out  (data_out),
        .cur_sel   (cur_sel),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input exp_t e);
        n_checks++;
        if (data_out !== e.d || cur_sel !== e.s || out_valid !== e.v || wrap !== e.w) begin
            n_err++;
            $display("FAIL %s: got d=%h sel=%0d valid=%b wrap=%b, expected d=%h sel=%0d valid=%b wrap=%b",
                     nm, data_out, cur_sel, out_valid, wrap, e.d, e.s, e.v, e.w);
        end
    endtask

    // Called just after a negedge with inputs already set; returns after the next negedge.
    task automatic cyc(input string nm, input logic [3:0] d, input logic [2:0] s, input logic w);
        exp_t e;
        e.d = d; e.s = s; e.v = 1'b1; e.w = w;
        sb.push_back(e);
        names.push_back(nm);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: one expected entry per observed edge.
    initial begin
        exp_t  me;
        string mn;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                me = sb.pop_front();
                mn = names.pop_front();
                chk(mn, me);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        exp_t z;
        z = '0;
        resetn  = 1'b0;
        data_in = '1;
        sel     = 3'd2;
        mode    = 1'b0;
        hold    = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", z);

        // IDLE exit into manual, all-ones data
        resetn = 1'b1;
        cyc("idle_exit", 4'hF, 3'd2, 1'b0);

        // Manual sweep, channel k = k+8
        data_in = {4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
        for (int i = 0; i < CH; i++) begin
            sel = 3'(i);
            cyc("manual_sweep", 4'(8 + i), 3'(i), 1'b0);
        end
        sel = 3'd7;
        cyc("manual_clamp", 4'hE, 3'd6, 1'b0);

        // Async reset from manual, then scan from reset
        resetn = 1'b0;
        mode   = 1'b1;
        #1;
        chk("rst_async_manual", z);
        @(negedge clk);
        resetn = 1'b1;
        for (int e = 1; e <= 43; e++) begin
            cyc(e == 29 ? "scan_wrap" : "scan_step",
                4'(8 + ((e - 1) / 4) % 7), 3'(((e - 1) / 4) % 7), e == 29);
        end

        // Hold at cur_sel=3, dwell_cnt=2
        hold = 1'b1;
        for (int i = 0; i < 10; i++) cyc("hold_frozen", 4'hB, 3'd3, 1'b0);
        hold = 1'b0;
        cyc("hold_rel1", 4'hB, 3'd3, 1'b0);
        cyc("hold_rel2", 4'hC, 3'd4, 1'b0);
        for (int i = 0; i < 3; i++) cyc("scan_ch4", 4'hC, 3'd4, 1'b0);
        cyc("scan_ch5", 4'hD, 3'd5, 1'b0);

        // Mode switch with hold on the same edge: mode wins
        mode = 1'b0;
        sel  = 3'd1;
        hold = 1'b1;
        cyc("to_manual", 4'h9, 3'd1, 1'b0);
        hold = 1'b0;
        mode = 1'b1;
        sel  = 3'd6;
        for (int i = 0; i < 4; i++) cyc("reenter_ch1", 4'h9, 3'd1, 1'b0);
        cyc("reenter_adv", 4'hA, 3'd2, 1'b0);

        // data_in change mid-dwell
        data_in[11:8] = 4'h5;
        cyc("data_chg", 4'h5, 3'd2, 1'b0);
        for (int i = 0; i < 2; i++) cyc("scan_ch2", 4'h5, 3'd2, 1'b0);
        for (int i = 0; i < 4; i++) cyc("scan_ch3", 4'hB, 3'd3, 1'b0);
        cyc("scan_ch4b", 4'hC, 3'd4, 1'b0);

        // Async reset mid-scan
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_async_scan", z);
        @(negedge clk);
        resetn = 1'b1;
        mode   = 1'b1;
        cyc("restart", 4'h8, 3'd0, 1'b0);
        cyc("restart2", 4'h8, 3'd0, 1'b0);

        @(posedge clk);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
